led_pong: RTL

LED_PONG -- requirements
Module: led_pong

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_debounce.sv | 43 ++++
 rtl/led_pong.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the LED pong game: FSM state encoding and
// the one-hot constants marking the two ends of the court.
package pong_pkg;

    typedef enum logic [2:0] {
        SERVE_L = 3'd0,
        SERVE_R = 3'd1,
        MOVE_R  = 3'd2,
        MOVE_L  = 3'd3,
        OVER    = 3'd4
    } state_t;

    localparam int MAX_LED = 64;

    // Right player's end is always bit 0; the left end depends on court length.
    localparam logic [MAX_LED-1:0] END_RIGHT = 64'd1;

    function automatic logic [MAX_LED-1:0] end_left(input int n_led);
        return END_RIGHT << (n_led - 1);
    endfunction

endpackage

// File: rtl/pong_debounce.sv
// Button conditioner: two-flop synchroniser, stable-high debouncer and
// a one-cycle press pulse on the rising edge of the debounced level.
module pong_debounce #(
    parameter int DEB_CNT = 3855
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            // Any low sample restarts the stability count.
            if (!sync[1]) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (cnt == LAST) begin
                level <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/led_pong.sv
// Two-player LED pong: a ball bounces along a row of LEDs and each player
// must hit it while it sits on their end LED; first to WIN_SCORE wins.
module led_pong
    import pong_pkg::*;
#(
    parameter int N_LED     = 8,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 9,
    parameter int STEP_INIT = 2**25,
    parameter int STEP_DEC  = 2**21,
    parameter int STEP_MIN  = 2**22,
    parameter int DEB_CNT   = 3855
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               show_score,
    output logic [N_LED-1:0]   led,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner
);

    localparam int P_W = $clog2(STEP_INIT + STEP_MIN + STEP_DEC + 1);
    localparam logic [P_W-1:0] P_INIT    = P_W'(STEP_INIT);
    localparam logic [P_W-1:0] P_DEC     = P_W'(STEP_DEC);
    localparam logic [P_W-1:0] P_MIN     = P_W'(STEP_MIN);
    localparam logic [P_W-1:0] P_MIN_DEC = P_W'(STEP_MIN + STEP_DEC);
    localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
    localparam logic [MAX_LED-1:0] LEFT_FULL = end_left(N_LED);
    localparam logic [N_LED-1:0] POS_L = LEFT_FULL[N_LED-1:0];
    localparam logic [N_LED-1:0] POS_R = END_RIGHT[N_LED-1:0];

    logic level_l, level_r, press_l, press_r;

    pong_debounce #(.DEB_CNT(DEB_CNT)) u_deb_l (
        .clk(clk), .rst(rst), .btn(btn_l), .level(level_l), .press(press_l)
    );
    pong_debounce #(.DEB_CNT(DEB_CNT)) u_deb_r (
        .clk(clk), .rst(rst), .btn(btn_r), .level(level_r), .press(press_r)
    );

    state_t             state, state_n;
    logic [N_LED-1:0]   pos, pos_n, led_n;
    logic [P_W-1:0]     cnt, cnt_n, period, period_n, period_fast;
    logic [SCORE_W-1:0] score_l_n, score_r_n;
    logic               winner_n, blink, blink_n, tick, point_l, point_r;

    assign tick        = (cnt == period - 1'b1);
    assign period_fast = (period < P_MIN_DEC) ? P_MIN : period - P_DEC;
    assign game_over   = (state == OVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SERVE_L;
            pos     <= POS_L;
            led     <= POS_L;
            cnt     <= '0;
            period  <= P_INIT;
            score_l <= '0;
            score_r <= '0;
            winner  <= 1'b0;
            blink   <= 1'b0;
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            led     <= led_n;
            cnt     <= cnt_n;
            period  <= period_n;
            score_l <= score_l_n;
            score_r <= score_r_n;
            winner  <= winner_n;
            blink   <= blink_n;
        end
    end

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        cnt_n     = cnt;
        period_n  = period;
        score_l_n = score_l;
        score_r_n = score_r;
        winner_n  = winner;
        blink_n   = blink;
        point_l   = 1'b0;
        point_r   = 1'b0;

        case (state)
            SERVE_L: if (press_l) begin
                state_n  = MOVE_R;
                cnt_n    = '0;
                period_n = P_INIT;
            end
            SERVE_R: if (press_r) begin
                state_n  = MOVE_L;
                cnt_n    = '0;
                period_n = P_INIT;
            end
            // A press takes priority over a coincident tick and sees the current position.
            MOVE_R: if (press_r) begin
                if (pos == POS_R) begin
                    state_n  = MOVE_L;
                    cnt_n    = '0;
                    period_n = period_fast;
                end else begin
                    point_l = 1'b1;
                end
            end else if (tick) begin
                if (pos == POS_R) point_l = 1'b1;
                else begin
                    pos_n = pos >> 1;
                    cnt_n = '0;
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
            MOVE_L: if (press_l) begin
                if (pos == POS_L) begin
                    state_n  = MOVE_R;
                    cnt_n    = '0;
                    period_n = period_fast;
                end else begin
                    point_r = 1'b1;
                end
            end else if (tick) begin
                if (pos == POS_L) point_r = 1'b1;
                else begin
                    pos_n = pos << 1;
                    cnt_n = '0;
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
            OVER: if (level_l && level_r) begin
                state_n   = SERVE_L;
                pos_n     = POS_L;
                cnt_n     = '0;
                period_n  = P_INIT;
                score_l_n = '0;
                score_r_n = '0;
                winner_n  = 1'b0;
                blink_n   = 1'b0;
            end else if (tick) begin
                cnt_n   = '0;
                blink_n = ~blink;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = SERVE_L;
        endcase

        // Scoring: the next serve goes to the player who won the point.
        if (point_l || point_r) begin
            cnt_n = '0;
            if (point_l) score_l_n = score_l + 1'b1;
            else         score_r_n = score_r + 1'b1;
            if ((point_l && score_l_n == WIN) || (point_r && score_r_n == WIN)) begin
                state_n  = OVER;
                winner_n = point_r;
                period_n = P_INIT;
                blink_n  = 1'b1;
            end else if (point_l) begin
                state_n = SERVE_L;
                pos_n   = POS_L;
            end else begin
                state_n = SERVE_R;
                pos_n   = POS_R;
            end
        end
    end

    always_comb begin
        led_n = pos;
        if (show_score) begin
            led_n = '0;
            led_n[N_LED-1 -: SCORE_W] = score_l;
            led_n[SCORE_W-1:0]        = score_r;
        end else if (state == OVER) begin
            led_n = {N_LED{blink}};
        end
    end

endmodule
